// File: rtl/decode_execute_memory.sv
// ID, EX and MEM stages of the 5-stage MIPS pipeline: register file, control, ALU,
// branch adder, data memory and the ID/EX, EX/MEM and MEM/WB pipeline registers.
module decode_execute_memory #(
  parameter int unsigned DMEM_WORDS = 256,
  parameter int unsigned REG_COUNT  = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] IF_ID_instr,
  input  logic [31:0] IF_ID_npc,
  input  logic [31:0] WB_writedata,
  output logic        EX_MEM_PCSrc,
  output logic [31:0] EX_MEM_NPC,
  output logic        MEM_WB_regwrite,
  output logic        MEM_WB_memtoreg,
  output logic [4:0]  MEM_WB_rd,
  output logic [31:0] read_data,
  output logic [31:0] mem_alu_result
);

  localparam int unsigned DW  = 32;
  localparam int unsigned RW  = 5;
  localparam int unsigned DAW = $clog2(DMEM_WORDS);

  localparam logic [5:0] OP_RTYPE = 6'd0;
  localparam logic [5:0] OP_LW    = 6'd35;
  localparam logic [5:0] OP_SW    = 6'd43;
  localparam logic [5:0] OP_BEQ   = 6'd4;

  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2A;

  // ---------------- ID ----------------
  logic [5:0]    id_op;
  logic [RW-1:0] id_rs, id_rt, id_rd;
  logic [DW-1:0] id_imm, id_rdata1, id_rdata2;
  logic          id_regdst, id_alusrc, id_branch, id_memread, id_memwrite;
  logic          id_regwrite, id_memtoreg;
  logic [1:0]    id_aluop;

  assign id_op  = IF_ID_instr[31:26];
  assign id_rs  = IF_ID_instr[25:21];
  assign id_rt  = IF_ID_instr[20:16];
  assign id_rd  = IF_ID_instr[15:11];
  assign id_imm = {{16{IF_ID_instr[15]}}, IF_ID_instr[15:0]};

  // Main control; unknown opcodes decode to an all-zero bubble.
  always_comb begin
    id_regdst   = 1'b0;
    id_alusrc   = 1'b0;
    id_aluop    = 2'b00;
    id_branch   = 1'b0;
    id_memread  = 1'b0;
    id_memwrite = 1'b0;
    id_regwrite = 1'b0;
    id_memtoreg = 1'b0;
    case (id_op)
      OP_RTYPE: begin
        id_regdst   = 1'b1;
        id_aluop    = 2'b10;
        id_regwrite = 1'b1;
      end
      OP_LW: begin
        id_alusrc   = 1'b1;
        id_memread  = 1'b1;
        id_regwrite = 1'b1;
        id_memtoreg = 1'b1;
      end
      OP_SW: begin
        id_alusrc   = 1'b1;
        id_memwrite = 1'b1;
      end
      OP_BEQ: begin
        id_aluop  = 2'b01;
        id_branch = 1'b1;
      end
      default: ;
    endcase
  end

  logic [DW-1:0] regs [REG_COUNT];

  // Write-first bypass so a writeback lands in the instruction decoded on the same edge.
  always_comb begin
    id_rdata1 = regs[id_rs];
    id_rdata2 = regs[id_rt];
    if (MEM_WB_regwrite && (MEM_WB_rd == id_rs)) id_rdata1 = WB_writedata;
    if (MEM_WB_regwrite && (MEM_WB_rd == id_rt)) id_rdata2 = WB_writedata;
    if (id_rs == '0) id_rdata1 = '0;
    if (id_rt == '0) id_rdata2 = '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < REG_COUNT; i++) regs[i] <= DW'(i);
    end else if (MEM_WB_regwrite && (MEM_WB_rd != '0)) begin
      regs[MEM_WB_rd] <= WB_writedata;
    end
  end

  // ---------------- ID/EX ----------------
  logic          id_ex_regwrite, id_ex_memtoreg, id_ex_branch, id_ex_memread, id_ex_memwrite;
  logic          id_ex_regdst, id_ex_alusrc;
  logic [1:0]    id_ex_aluop;
  logic [DW-1:0] id_ex_npc, id_ex_rdata1, id_ex_rdata2, id_ex_imm;
  logic [RW-1:0] id_ex_rt, id_ex_rd;

  always_ff @(posedge clk) begin
    if (rst) begin
      id_ex_regwrite <= 1'b0;
      id_ex_memtoreg <= 1'b0;
      id_ex_branch   <= 1'b0;
      id_ex_memread  <= 1'b0;
      id_ex_memwrite <= 1'b0;
      id_ex_regdst   <= 1'b0;
      id_ex_alusrc   <= 1'b0;
      id_ex_aluop    <= 2'b00;
      id_ex_npc      <= '0;
      id_ex_rdata1   <= '0;
      id_ex_rdata2   <= '0;
      id_ex_imm      <= '0;
      id_ex_rt       <= '0;
      id_ex_rd       <= '0;
    end else begin
      id_ex_regwrite <= id_regwrite;
      id_ex_memtoreg <= id_memtoreg;
      id_ex_branch   <= id_branch;
      id_ex_memread  <= id_memread;
      id_ex_memwrite <= id_memwrite;
      id_ex_regdst   <= id_regdst;
      id_ex_alusrc   <= id_alusrc;
      id_ex_aluop    <= id_aluop;
      id_ex_npc      <= IF_ID_npc;
      id_ex_rdata1   <= id_rdata1;
      id_ex_rdata2   <= id_rdata2;
      id_ex_imm      <= id_imm;
      id_ex_rt       <= id_rt;
      id_ex_rd       <= id_rd;
    end
  end

  // ---------------- EX ----------------
  logic [DW-1:0] ex_b, ex_alu, ex_target;
  logic [RW-1:0] ex_wreg;
  logic          ex_zero;

  assign ex_b      = id_ex_alusrc ? id_ex_imm : id_ex_rdata2;
  assign ex_wreg   = id_ex_regdst ? id_ex_rd : id_ex_rt;
  assign ex_target = id_ex_npc + {id_ex_imm[DW-3:0], 2'b00};
  assign ex_zero   = (ex_alu == '0);

  // ALU control folded into the ALU; funct is the low six bits of the immediate.
  always_comb begin
    ex_alu = '0;
    case (id_ex_aluop)
      2'b00: ex_alu = id_ex_rdata1 + ex_b;
      2'b01: ex_alu = id_ex_rdata1 - ex_b;
      2'b10: begin
        case (id_ex_imm[5:0])
          FN_ADD:  ex_alu = id_ex_rdata1 + ex_b;
          FN_SUB:  ex_alu = id_ex_rdata1 - ex_b;
          FN_AND:  ex_alu = id_ex_rdata1 & ex_b;
          FN_OR:   ex_alu = id_ex_rdata1 | ex_b;
          FN_SLT:  ex_alu = {{(DW-1){1'b0}}, ($signed(id_ex_rdata1) < $signed(ex_b))};
          default: ex_alu = '0;
        endcase
      end
      default: ex_alu = '0;
    endcase
  end

  // ---------------- EX/MEM ----------------
  logic          ex_mem_regwrite, ex_mem_memtoreg, ex_mem_branch, ex_mem_memread, ex_mem_memwrite;
  logic          ex_mem_zero;
  logic [DW-1:0] ex_mem_alu_result, ex_mem_rdata2;
  logic [RW-1:0] ex_mem_wreg;

  always_ff @(posedge clk) begin
    if (rst) begin
      ex_mem_regwrite   <= 1'b0;
      ex_mem_memtoreg   <= 1'b0;
      ex_mem_branch     <= 1'b0;
      ex_mem_memread    <= 1'b0;
      ex_mem_memwrite   <= 1'b0;
      ex_mem_zero       <= 1'b0;
      ex_mem_alu_result <= '0;
      ex_mem_rdata2     <= '0;
      EX_MEM_NPC        <= '0;
      ex_mem_wreg       <= '0;
    end else begin
      ex_mem_regwrite   <= id_ex_regwrite;
      ex_mem_memtoreg   <= id_ex_memtoreg;
      ex_mem_branch     <= id_ex_branch;
      ex_mem_memread    <= id_ex_memread;
      ex_mem_memwrite   <= id_ex_memwrite;
      ex_mem_zero       <= ex_zero;
      ex_mem_alu_result <= ex_alu;
      ex_mem_rdata2     <= id_ex_rdata2;
      EX_MEM_NPC        <= ex_target;
      ex_mem_wreg       <= ex_wreg;
    end
  end

  assign EX_MEM_PCSrc = ex_mem_branch & ex_mem_zero;

  // ---------------- MEM ----------------
  logic [DW-1:0]  dmem [DMEM_WORDS];
  logic [DAW-1:0] dmem_addr;
  logic [DW-1:0]  dmem_rdata;

  assign dmem_addr  = ex_mem_alu_result[DAW+1:2];
  assign dmem_rdata = dmem[dmem_addr];

  // Not reset; a store caught in EX/MEM by reset is discarded with the rest of the pipe.
  always_ff @(posedge clk) begin
    if (!rst && ex_mem_memwrite) dmem[dmem_addr] <= ex_mem_rdata2;
  end

  // ---------------- MEM/WB ----------------
  always_ff @(posedge clk) begin
    if (rst) begin
      MEM_WB_regwrite <= 1'b0;
      MEM_WB_memtoreg <= 1'b0;
      MEM_WB_rd       <= '0;
      read_data       <= '0;
      mem_alu_result  <= '0;
    end else begin
      MEM_WB_regwrite <= ex_mem_regwrite;
      MEM_WB_memtoreg <= ex_mem_memtoreg;
      MEM_WB_rd       <= ex_mem_wreg;
      read_data       <= ex_mem_memread ? dmem_rdata : '0;
      mem_alu_result  <= ex_mem_alu_result;
    end
  end

endmodule

// File: tb/tb_decode_execute_memory.sv
// Bench for decode_execute_memory: directed program plus random instruction stream,
// checked against an instruction-level reference model with a three-deep result pipe.
module tb_decode_execute_memory;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] instr, npc, wbdata;
  logic        pcsrc;
  logic [31:0] tgt;
  logic        wb_rw, wb_m2r;
  logic [4:0]  wb_rd;
  logic [31:0] rdata, alu;

  always #5 clk = ~clk;

  decode_execute_memory dut (
    .clk             (clk),
    .rst             (rst),
    .IF_ID_instr     (instr),
    .IF_ID_npc       (npc),
    .WB_writedata    (wbdata),
    .EX_MEM_PCSrc    (pcsrc),
    .EX_MEM_NPC      (tgt),
    .MEM_WB_regwrite (wb_rw),
    .MEM_WB_memtoreg (wb_m2r),
    .MEM_WB_rd       (wb_rd),
    .read_data       (rdata),
    .mem_alu_result  (alu)
  );

  // Architectural result of one instruction, as seen at the pipeline outputs.
  typedef struct packed {
    logic        rw;
    logic        m2r;
    logic [4:0]  rd;
    logic [31:0] alu;
    logic [31:0] rdata;
    logic        pcsrc;
    logic [31:0] tgt;
  } exp_t;

  exp_t        pipe_q[$];
  logic [31:0] mreg [32];
  logic [31:0] mmem [256];
  logic [31:0] pc;
  int          n_checks = 0;
  int          n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    exp_t z;
    z = '0;
    for (int i = 0; i < 32; i++) mreg[i] = 32'(i);
    pipe_q.delete();
    for (int i = 0; i < 3; i++) pipe_q.push_back(z);
  endtask

  // Executes a whole instruction at decode time; memory is effectively program-ordered.
  task automatic model_edge(input logic r, input logic [31:0] ins, input logic [31:0] np,
                            input logic [31:0] wb);
    exp_t        e, w;
    logic [31:0] a, b, imm;
    logic [5:0]  op, fn;
    logic [4:0]  rs, rt, rd;
    if (r) begin
      model_reset();
      return;
    end
    w = pipe_q[2];
    if (w.rw && w.rd != 5'd0) mreg[w.rd] = wb;
    op  = ins[31:26];
    rs  = ins[25:21];
    rt  = ins[20:16];
    rd  = ins[15:11];
    fn  = ins[5:0];
    imm = {{16{ins[15]}}, ins[15:0]};
    a   = (rs == 5'd0) ? 32'd0 : mreg[rs];
    b   = (rt == 5'd0) ? 32'd0 : mreg[rt];
    e     = '0;
    e.rd  = rt;
    e.tgt = np + imm * 4;
    case (op)
      6'd0: begin
        e.rw = 1'b1;
        e.rd = rd;
        case (fn)
          6'h20:   e.alu = a + b;
          6'h22:   e.alu = a - b;
          6'h24:   e.alu = a & b;
          6'h25:   e.alu = a | b;
          6'h2A:   e.alu = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
          default: e.alu = 32'd0;
        endcase
      end
      6'd35: begin
        e.alu   = a + imm;
        e.rdata = mmem[e.alu[9:2]];
        e.rw    = 1'b1;
        e.m2r   = 1'b1;
      end
      6'd43: begin
        e.alu = a + imm;
        mmem[e.alu[9:2]] = b;
      end
      6'd4: begin
        e.alu   = a - b;
        e.pcsrc = (e.alu == 32'd0);
      end
      default: e.alu = a + b;
    endcase
    pipe_q.push_front(e);
    void'(pipe_q.pop_back());
  endtask

  task automatic cycle(input logic [31:0] ins, input logic [31:0] np, input logic r);
    exp_t e1, e2;
    instr = ins;
    npc   = np;
    rst   = r;
    @(posedge clk);
    model_edge(r, ins, np, wbdata);
    #1;
    e1 = pipe_q[1];
    e2 = pipe_q[2];
    check("pcsrc",    32'(pcsrc),  32'(e1.pcsrc));
    check("target",   tgt,         e1.tgt);
    check("regwrite", 32'(wb_rw),  32'(e2.rw));
    check("memtoreg", 32'(wb_m2r), 32'(e2.m2r));
    check("wb_rd",    32'(wb_rd),  32'(e2.rd));
    check("read_data", rdata,      e2.rdata);
    check("alu",      alu,         e2.alu);
    wbdata = e2.m2r ? e2.rdata : e2.alu;
  endtask

  task automatic issue(input logic [31:0] ins);
    pc = pc + 32'd4;
    cycle(ins, pc, 1'b0);
  endtask

  task automatic nops(input int n);
    for (int i = 0; i < n; i++) issue(32'h0);
  endtask

  function automatic logic [31:0] rand_instr();
    logic [5:0]  fn_tab [6];
    logic [5:0]  op, fn;
    logic [4:0]  rs, rt, rd;
    logic [15:0] imm;
    int unsigned k;
    fn_tab[0] = 6'h20; fn_tab[1] = 6'h22; fn_tab[2] = 6'h24;
    fn_tab[3] = 6'h25; fn_tab[4] = 6'h2A; fn_tab[5] = 6'($urandom);
    k   = $urandom_range(0, 9);
    rs  = 5'($urandom);
    rt  = 5'($urandom);
    rd  = 5'($urandom);
    imm = 16'($urandom);
    fn  = fn_tab[$urandom_range(0, 5)];
    case (k)
      0, 1, 2, 3: return {6'd0, rs, rt, rd, 5'd0, fn};
      4, 5:       op = 6'd35;
      6:          op = 6'd43;
      7, 8: begin
        op = 6'd4;
        if ($urandom_range(0, 1) == 1) rt = rs;
      end
      default:    op = 6'($urandom);
    endcase
    return {op, rs, rt, imm};
  endfunction

  initial begin
    instr  = 32'h0;
    npc    = 32'h0;
    wbdata = 32'h0;
    rst    = 1'b1;
    pc     = 32'h0;
    model_reset();

    // Reset and idle
    cycle(32'h0, 32'h0, 1'b1);
    cycle(32'h0, 32'h0, 1'b1);
    check("rst_alu", alu, 32'h0);
    check("rst_rw", 32'(wb_rw), 32'h0);
    check("rst_pcsrc", 32'(pcsrc), 32'h0);
    check("rst_npc", tgt, 32'h0);
    nops(3);

    // R-type arithmetic
    issue(32'h00221820); nops(2);
    check("add_alu", alu, 32'd3);
    check("add_rd", 32'(wb_rd), 32'd3);
    check("add_rw", 32'(wb_rw), 32'd1);
    check("add_m2r", 32'(wb_m2r), 32'd0);
    issue(32'h00604820); nops(2);
    check("read_r3", alu, 32'd3);
    issue(32'h00222022); nops(2);
    check("sub_alu", alu, 32'hFFFF_FFFF);
    issue(32'h0041202A); nops(2);
    check("slt_alu", alu, 32'd0);
    issue(32'h00222025); nops(2);
    check("or_alu", alu, 32'd3);

    // Store then load
    issue(32'hAC050008); nops(2);
    check("sw_rw", 32'(wb_rw), 32'd0);
    nops(1);
    issue(32'h8C060008); nops(2);
    check("lw_data", rdata, 32'd5);
    check("lw_alu", alu, 32'd8);
    check("lw_rd", 32'(wb_rd), 32'd6);
    check("lw_m2r", 32'(wb_m2r), 32'd1);

    // Branches
    cycle(32'h10210003, 32'h10, 1'b0); nops(1);
    check("beq_taken", 32'(pcsrc), 32'd1);
    check("beq_target", tgt, 32'h1C);
    nops(1);
    check("beq_oneshot", 32'(pcsrc), 32'd0);
    cycle(32'h10220003, 32'h10, 1'b0); nops(1);
    check("beq_not_taken", 32'(pcsrc), 32'd0);
    nops(2);

    // Writeback bypass and $0
    issue(32'h00223820); nops(2);
    issue(32'h00E04020); nops(2);
    check("bypass_r7", alu, 32'd3);
    issue(32'h00220020); nops(2);
    issue(32'h00005020); nops(2);
    check("r0_zero", alu, 32'd0);

    // Fill data memory so random loads are well defined
    for (int k = 0; k < 256; k++) issue({6'd43, 5'd0, 5'(k), 16'(k * 4)});

    for (int i = 0; i < 300; i++) issue(rand_instr());

    // Mid-stream reset discards in-flight work and reinitialises registers
    nops(3);
    cycle(rand_instr(), 32'h0, 1'b1);
    issue(32'h00A66020); nops(2);
    check("post_rst_add", alu, 32'd11);

    for (int i = 0; i < 300; i++) issue(rand_instr());
    nops(4);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/decode_execute_memory.md
Name: decode_execute_memory

Overview:
- Combined ID, EX and MEM stages of the lab's 5-stage MIPS pipeline.
- Sits between the instruction-fetch stage and the external writeback mux.
- Contains the register file, main control, sign extend, ALU control, ALU, branch adder, data memory, and the ID/EX, EX/MEM and MEM/WB pipeline registers.
- Sends the branch decision and target back to fetch.

Parameters:
DMEM_WORDS, 256, data-memory depth in 32-bit words; indexed by alu_result[9:2]
REG_COUNT, 32, register-file depth; fixed at 32

Ports:
clk  in  1  single clock; all state updates on the rising edge
rst  in  1  synchronous, active-high reset
IF_ID_instr  in  32  instruction from the IF/ID register
IF_ID_npc  in  32  PC+4 from the IF/ID register
WB_writedata  in  32  externally muxed writeback data: MEM_WB_memtoreg ? read_data : mem_alu_result
EX_MEM_PCSrc  out  1  branch taken = EX/MEM.branch & EX/MEM.zero (combinational from EX/MEM)
EX_MEM_NPC  out  32  registered branch target
MEM_WB_regwrite  out  1  registered regwrite
MEM_WB_memtoreg  out  1  registered memtoreg
MEM_WB_rd  out  5  registered destination register
read_data  out  32  registered data-memory read value
mem_alu_result  out  32  registered ALU result

Behaviour:
- Reset (sync, high): all ID/EX, EX/MEM and MEM/WB fields clear to 0, so every output is 0. Register i is set to value i ($0=0). Data memory is not reset.
- Decoding follows standard MIPS fields: op[31:26], rs[25:21], rt[20:16], rd[15:11], funct[5:0], imm[15:0] sign-extended to 32 bits.
- Control settings by opcode:
  - R-type (0): regdst=1, alusrc=0, aluop=10, regwrite=1, all others 0.
  - lw (35): alusrc=1, aluop=00, memread=1, regwrite=1, memtoreg=1.
  - sw (43): alusrc=1, aluop=00, memwrite=1.
  - beq (4): aluop=01, branch=1.
  - Any other opcode: all control bits 0 (bubble).
- Register file reads are combinational on rs and rt.
- Register write happens on the rising edge when MEM_WB_regwrite=1 and MEM_WB_rd!=0, storing WB_writedata.
- Same-cycle write/read: when the write address equals the read address (and is nonzero), the read returns WB_writedata (write-first bypass).
- Register $0 always reads 0.
- ID/EX latches: wb{regwrite,memtoreg}, m{branch,memread,memwrite}, regdst, alusrc, aluop, npc, rdata1, rdata2, sign-extended imm, rt, rd.
- EX stage:
  - ALU operand B = alusrc ? imm : rdata2.
  - Write register = regdst ? rd : rt.
  - Branch target = npc + (imm<<2), modulo 2^32.
- ALU control:
  - aluop 00: add. aluop 01: sub.
  - aluop 10, by funct: 0x20 add, 0x22 sub, 0x24 and, 0x25 or, 0x2A signed slt (1/0).
  - Any other combination: result 0.
- zero = (ALU result == 0). Arithmetic is 32-bit wraparound; no overflow trap.
- EX/MEM latches: wb, branch, memread, memwrite, zero, alu_result, rdata2, target, write register.
- MEM stage:
  - Memory read is combinational at word address alu_result[9:2] (bits 1:0 ignored; upper bits ignored).
  - Memory write occurs on the rising edge when memwrite=1.
  - A read of a location being written in the same cycle returns the old value.
  - read_data latches the memory output only when memread=1; otherwise it latches 0.
- Latency: an instruction presented at IF_ID at edge 0 is latched into ID/EX at edge 1, EX/MEM at edge 2, MEM/WB at edge 3, and its register write happens at edge 4. EX_MEM_PCSrc and EX_MEM_NPC are valid after edge 2, for one cycle.
- No hazard detection, no forwarding, no flush: software inserts NOPs. A taken branch does not squash younger instructions.
- Reset asserted mid-operation: all in-flight instructions are discarded at that edge and the register file is reinitialised.

Test Plan:
1. rst=1 for 2 cycles -> all outputs 0. After release with NOP (0x00000000) input -> outputs stay 0 (MEM_WB_regwrite=1 with rd=0 is harmless).
2. add $3,$1,$2 (0x00221820), then NOPs -> after edge 3: mem_alu_result=3, MEM_WB_rd=3, regwrite=1, memtoreg=0. Bench feeds WB_writedata=3. A later read of $3 returns 3.
3. sub $4,$1,$2 (0x00222022) -> mem_alu_result=0xFFFFFFFF. slt $4,$2,$1 (0x0041202A) -> 0. or $4,$1,$2 (0x00222025) -> 3.
4. sw $5,8($0) (0xAC050008), 3 NOPs, lw $6,8($0) (0x8C060008) -> sw produces MEM_WB_regwrite=0. lw produces read_data=5, mem_alu_result=8, MEM_WB_rd=6, memtoreg=1.
5. beq $1,$1,3 (0x10210003) with npc=0x10 -> after edge 2: EX_MEM_PCSrc=1 for exactly one cycle, EX_MEM_NPC=0x1C. beq $1,$2,3 (0x10220003) -> PCSrc=0.
6. Writeback to $7 in the same cycle that add $8,$7,$0 is decoded -> the new $7 value is used (bypass). Writeback to $0 -> $0 still reads 0.
